// File: rtl/gen_decoder.sv
// N-to-2**N one-hot decoder with enable.
// All outputs are zero while en is low.
module gen_decoder #(
   parameter int N = 8
) (
   input  logic            en,
   input  logic [N-1:0]    addr,
   output logic [2**N-1:0] y
);

   always_comb begin
      y = '0;
      if (en) y[addr] = 1'b1;
   end

endmodule

// File: rtl/gen_demux_regs.sv
// Write-side register bank: handshaked 1-to-2**N write demux
// feeding 2**N registers, plus a one-register-per-cycle bank clear.
module gen_demux_regs #(
   parameter int size     = 4,
   parameter int N        = 8,
   parameter int ZERO_REG = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [N-1:0]          wr_addr,
   input  logic [size-1:0]       wr_data,
   input  logic                  clear,
   output logic                  busy,
   output logic                  clear_done,
   output logic [size*(2**N)-1:0] Q
);

   localparam int        R     = 2**N;
   localparam logic      IDLE  = 1'b0;
   localparam logic      CLEAR = 1'b1;
   localparam logic [N-1:0] LAST = '1;

   logic            state;
   logic [N-1:0]    cnt;
   logic            accept;
   logic            dec_en;
   logic [N-1:0]    dec_addr;
   logic [R-1:0]    onehot;
   logic [size-1:0] regs [R];

   assign wr_ready   = (state == IDLE) && !clear && !reset;
   assign accept     = wr_valid && wr_ready;
   assign busy       = (state == CLEAR);
   assign clear_done = (state == CLEAR) && (cnt == LAST);

   // The sweep borrows the write decoder to pick the register to zero.
   assign dec_en   = accept || (state == CLEAR);
   assign dec_addr = (state == CLEAR) ? cnt : wr_addr;

   gen_decoder #(.N(N)) u_dec (
      .en   (dec_en),
      .addr (dec_addr),
      .y    (onehot)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (clear) begin
                  state <= CLEAR;
                  cnt   <= '0;
               end
            end
            CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == LAST) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < R; k++) begin : g_reg
      if ((ZERO_REG != 0) && (k == 0)) begin : g_zero
         assign regs[k] = '0;
      end else begin : g_ff
         always_ff @(posedge clock or posedge reset) begin
            if (reset)
               regs[k] <= '0;
            else if (onehot[k])
               regs[k] <= (state == CLEAR) ? '0 : wr_data;
         end
      end
      assign Q[k*size +: size] = regs[k];
   end

endmodule
